// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multiport integer register file.
package regfile_pkg;

  localparam int          REG_ZERO    = 0;
  localparam int          SP_IDX_DEF  = 2;
  localparam logic [31:0] MEM_DEPTH   = 32'h0000_4000;
  localparam logic [31:0] SP_INIT_DEF = 32'h0100_0000 + MEM_DEPTH;

  // Address width for a register count; at least one bit so NREGS=2 still works.
  function automatic int addr_width(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: issue sets, writeback clears, issue wins on a tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NUM_WR = 1,
  parameter int AW     = addr_width(NREGS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic [NREGS-1:0]     busy_vec
);

  logic [NREGS-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy_vec;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
    end
    // Set after clear: the issuing instruction is the newer producer.
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) busy_vec <= '0;
    else       busy_vec <= busy_nxt;
  end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multi-read/multi-write register file with reset-to-architectural-state.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int              XLEN    = 32,
  parameter int              NREGS   = 32,
  parameter int              NUM_RD  = 2,
  parameter int              NUM_WR  = 1,
  parameter int              SP_IDX  = SP_IDX_DEF,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*addr_width(NREGS)-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*addr_width(NREGS)-1:0] wr_addr,
  input  logic [NUM_WR*XLEN-1:0]   wr_data,
  input  logic                     iss_en,
  input  logic [addr_width(NREGS)-1:0] iss_addr,
  output logic [NREGS-1:0]         busy_vec
);

  localparam int AW = addr_width(NREGS);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
    end else begin
      // Later ports overwrite earlier ones, so the highest-numbered port wins.
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(REG_ZERO)))
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_addr[k*AW +: AW] != AW'(REG_ZERO))
        rd_data[k*XLEN +: XLEN] = regs[rd_addr[k*AW +: AW]];
      rd_busy[k] = busy_vec[rd_addr[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW]) &&
            (rd_addr[k*AW +: AW] != AW'(REG_ZERO))) begin
          rd_data[k*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
          rd_busy[k] = iss_en && (iss_addr == rd_addr[k*AW +: AW]);
        end
      end
`endif
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NUM_WR (NUM_WR),
    .AW     (AW)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec)
  );

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the core's single-write/dual-read integer register file.
- Adds configurable width, depth and read/write port counts, synchronous reset-to-architectural-state, and a per-register pending (scoreboard) bit.
- Sits between decode (reads, issue marking) and writeback (writes). Serves the dual-issue pipeline as well as the current single-issue core.

Parameters:
- XLEN, 32, register data width in bits.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- NUM_RD, 2, number of read ports.
- NUM_WR, 1, number of write ports.
- SP_IDX, 2, index of the stack-pointer register.
- SP_INIT, 32'h0100_0000 + MEM_DEPTH, value loaded into register SP_IDX on reset.
- AW (derived, localparam), clog2(NREGS), address width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*AW  packed read addresses; port k at [k*AW +: AW]
- rd_data  out  NUM_RD*XLEN  packed read data, combinational
- rd_busy  out  NUM_RD  pending bit of each addressed register, combinational
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*AW  packed write addresses
- wr_data  in  NUM_WR*XLEN  packed write data
- iss_en  in  1  mark register iss_addr as pending (producer issued)
- iss_addr  in  AW  destination register of the issuing instruction
- busy_vec  out  NREGS  full pending-bit vector, registered

Behaviour:
- Clocking: one clock, "clock". Reset is synchronous and active-high, named "reset". It is sampled only on the rising edge of clock.
- Reset: on a clock edge with reset=1:
  - Every register is cleared to 0, except register SP_IDX, which is loaded with SP_INIT.
  - busy_vec is cleared to 0.
  - Writes and issues presented in that same cycle are ignored.
  - Reset mid-operation discards all pending state with no partial update.
- Register 0:
  - Always reads 0.
  - Writes to it are dropped.
  - Its busy bit is forced to 0, so iss_en with iss_addr=0 has no effect.
- Reads:
  - Purely combinational, 0-cycle latency.
  - rd_data[k] = reg[rd_addr[k]].
  - All read ports are independent; any addresses, including duplicates, are legal.
- Writes:
  - Registered at the rising edge; the value is visible to reads in the next cycle.
  - Port j writes wr_data[j] to reg[wr_addr[j]] when wr_en[j]=1 and wr_addr[j] != 0.
- Write conflict: if two enabled ports target the same register, the highest-numbered port wins. No error is flagged.
- Scoreboard, updated at each rising edge:
  - Set: iss_en=1 sets busy[iss_addr].
  - Clear: each enabled write clears busy[wr_addr[j]].
  - Simultaneous set and clear of the same register: set wins, because the issue belongs to a newer producer.
- rd_busy[k] = busy_vec[rd_addr[k]], subject to the bypass rule under Optional Feature.
- Out-of-range addresses are impossible, since NREGS is a power of two.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding. If any enabled write port targets rd_addr[k] (non-zero) in the current cycle, rd_data[k] returns that wr_data; the highest-numbered matching port wins.
  - rd_busy[k] is then forced to 0, unless iss_en targets the same register in the same cycle.
- Undefined:
  - Reads in the write cycle return the old value.
  - rd_busy reflects the registered busy_vec only.
  - The pipeline must then stall one extra cycle.

Decomposition:
- Package regfile_pkg holds:
  - the REG_ZERO index constant;
  - the SP_IDX default;
  - the SP_INIT default, derived from MEM_DEPTH;
  - the helper that derives AW from NREGS.
- Sub-module regfile_scoreboard owns busy_vec, the set/clear priority logic and the x0 masking. It is instantiated once inside regfile_multiport.

Test Plan:
- Reset → after one edge with reset=1, read all 32 registers: reg2 = SP_INIT, all others 0, busy_vec = 0.
- Write/read → write 32'hDEAD_BEEF to x5 via port 0. Next cycle rd_addr[0]=5 returns DEAD_BEEF. Write 32'h1234 to x0: x0 still reads 0.
- Port conflict (NUM_WR=2) → both ports write x7, with values 32'hA (port 0) and 32'hB (port 1): x7 reads 32'hB.
- Scoreboard → iss_en with x9 sets busy_vec[9]. A later write to x9 clears it. Issue and write of x9 in the same cycle leave busy_vec[9]=1. iss_en with x0 leaves busy_vec[0]=0.
- Bypass → write 32'h55 to x3 while rd_addr[1]=3 in the same cycle:
  - with REGFILE_BYPASS_EN: rd_data[1]=32'h55, rd_busy[1]=0;
  - without it: the old value is returned.
- Reset mid-operation → with x4 busy and a write to x4 pending, assert reset in that cycle: x4=0 and busy_vec=0 afterwards.
